// File: rtl/cpu_pkg.sv
// Shared fetch-path types: fetch FSM states, prefetch queue entry layout, PC step.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ifq_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/ifq_ram.sv
// Prefetch queue storage: DEPTH entries, one synchronous write port, one async read port.
module ifq_ram
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  ifq_entry_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output ifq_entry_t                 rdata
);

  ifq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM feeding a DEPTH-entry FIFO.
// Define IFQ_STALL_STATS_EN to add the saturating stall_cycles counter output.
module if_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     im_req,
  output logic [31:0]              im_addr,
  input  logic                     im_ack,
  input  logic [31:0]              im_data,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_inst,
  output logic [31:0]              id_pc4,
  output logic [$clog2(DEPTH):0]   count
`ifdef IFQ_STALL_STATS_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          space;
  ifq_entry_t    wr_entry;
  ifq_entry_t    head;

  assign id_valid = (count != '0);
  assign pop      = id_valid && id_ready && !redirect;
  assign push     = (state == WAIT) && im_ack && !redirect;
  // A pop in the same cycle frees a slot, so a full queue can issue immediately.
  assign space    = (count != FULL) || pop;
  assign wr_entry = '{pc4: fetch_pc + PC_STEP, inst: im_data};
  assign id_inst  = id_valid ? head.inst : '0;
  assign id_pc4   = id_valid ? head.pc4  : '0;

  ifq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (Clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // im_addr is its own register so DROP keeps presenting the abandoned address
  // while fetch_pc already tracks the redirect target.
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      im_req   <= 1'b0;
      im_addr  <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redirect) begin
        fetch_pc <= redirect_pc;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + AW'(1);
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end

      case (state)
        IDLE: begin
          if (space && !redirect) begin
            state   <= WAIT;
            im_req  <= 1'b1;
            im_addr <= fetch_pc;
          end
        end
        WAIT: begin
          if (im_ack) begin
            state  <= IDLE;
            im_req <= 1'b0;
          end else if (redirect) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (im_ack) begin
            state  <= IDLE;
            im_req <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          im_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_STALL_STATS_EN
  always_ff @(posedge Clock) begin
    if (Resetn)                              stall_cycles <= '0;
    else if (!id_valid && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Resetn  input  1  reset, synchronous and active-high (Resetn=1 resets on the next Clock edge).
REQ-005 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address (bpc/jpc already selected by pcsource).
REQ-007 SHALL have port im_req  output  1  instruction-memory read request.
REQ-008 SHALL have port im_addr  output  32  word address of the request.
REQ-009 SHALL have port im_ack  input  1  read data valid this cycle.
REQ-010 SHALL have port im_data  input  32  instruction word.
REQ-011 SHALL have port id_valid  output  1  head entry valid toward the IF/ID register.
REQ-012 SHALL have port id_ready  input  1  IF/ID register accepts the head entry.
REQ-013 SHALL have port id_inst  output  32  head instruction.
REQ-014 SHALL have port id_pc4  output  32  head instruction address + 4.
REQ-015 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL implement fetch FSM states IDLE, WAIT, DROP.
REQ-017 IDLE: SHALL assert im_req and go to WAIT when count < DEPTH and redirect=0; otherwise stay in IDLE with im_req=0.
REQ-018 WAIT: SHALL hold im_req=1 and a stable im_addr until im_ack. On im_ack, SHALL push {fetch_pc+4, im_data}, advance fetch_pc by 4 and return to IDLE. Only one request is ever outstanding.
REQ-019 SHALL issue back-to-back requests: an ack in WAIT with space remaining returns to IDLE, and the next request is issued the cycle after.
REQ-020 SHALL pop the head when id_valid=1 and id_ready=1; id_valid=(count!=0); id_inst/id_pc4 SHALL come from the registered head entry.
REQ-021 SHALL latch im_data on ack and show it on id_* no earlier than the next cycle (one-cycle ack-to-id_valid latency when empty).
REQ-022 Simultaneous push and pop SHALL leave count unchanged; count SHALL never exceed DEPTH or go below 0.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 redirect SHALL take priority over push and pop in the same cycle: count<=0, fetch_pc<=redirect_pc, id_valid=0 the next cycle.
REQ-025 redirect in WAIT without im_ack SHALL go to DROP. DROP holds im_req with the old im_addr until im_ack, discards that data, then returns to IDLE.
REQ-026 redirect in the same cycle as im_ack in WAIT SHALL discard that data and go to IDLE.
REQ-027 redirect in DROP SHALL update fetch_pc again and remain in DROP (or go to IDLE if im_ack arrives in that cycle).

Reset
REQ-028 On Resetn=1 SHALL set: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, im_req=0, id_valid=0, id_inst=0, id_pc4=0.
REQ-029 Reset SHALL override redirect, im_ack and id_ready. An outstanding memory ack after reset is not tracked; the memory is reset by the same Resetn.

Configuration
REQ-030 With macro IFQ_STALL_STATS_EN defined, the module SHALL add output stall_cycles (32 bits). The counter increments each cycle id_valid=0 and Resetn=0, saturates at 32'hFFFF_FFFF, and is cleared by reset.
REQ-031 Without IFQ_STALL_STATS_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Shared package cpu_pkg SHALL hold: the FSM state enum (IDLE/WAIT/DROP), the entry typedef {pc4[31:0], inst[31:0]}, and constant PC_STEP=4.
REQ-033 Storage SHALL be one sub-module, ifq_ram (DEPTH x 64-bit register array, single write port, single async read port); the FSM and pointers live in the top.

Verification
REQ-034 Reset then im_ack every cycle after a request, id_ready=1 -> im_addr sequence 0x0,0x4,0x8; id_pc4 sequence 0x4,0x8,0xC; first id_valid one cycle after the first ack.
REQ-035 id_ready=0 with immediate acks -> count reaches 4, im_req=0 while full. One pop then frees the slot, and im_req=1 on the next cycle.
REQ-036 redirect with redirect_pc=0x100 while count=3 and in WAIT -> count=0 and id_valid=0 next cycle. The pending ack is discarded. The next request has im_addr=0x100 and the first id_pc4=0x104.
REQ-037 redirect in the same cycle as im_ack and a pop -> the acked data never appears on id_inst and count=0.
REQ-038 Resetn asserted mid-WAIT with count=2 -> all outputs at reset values the next cycle, and the next im_addr=RESET_PC.
REQ-039 With IFQ_STALL_STATS_EN: 5 empty cycles after reset -> stall_cycles=5. Forcing the count to 32'hFFFF_FFFF -> it holds that value.
